// File: rtl/xtime_axi_pkg.sv
// Shared types and helpers for the X-TIME AXI read-address path.
package xtime_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } xtime_ar_state_e;

  // Bytes covered by one full AR burst; also the address stride between bursts.
  function automatic int calc_burst_bytes(input int burst_len, input int bytes_per_beat);
    return burst_len * bytes_per_beat;
  endfunction

  // Counter must be able to hold the value max_outstanding itself.
  function automatic int calc_cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/xtime_rd_ar_issuer_counter.sv
// Up/down counter with load; simultaneous incr and decr cancel out.
module alt_counter #(
  parameter int                 C_WIDTH = 4,
  parameter logic [C_WIDTH-1:0] C_INIT  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [C_WIDTH-1:0] load_value,
  input  logic               incr,
  input  logic               decr,
  output logic [C_WIDTH-1:0] count,
  output logic               is_zero
);

  // Count register: load has priority, then a net increment or decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= C_INIT;
    end else if (load) begin
      count <= load_value;
    end else if (incr && !decr) begin
      count <= count + C_WIDTH'(1);
    end else if (decr && !incr) begin
      count <= count - C_WIDTH'(1);
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/xtime_rd_ar_issuer.sv
// Read-address issuer: splits a transfer into AR bursts, limits in-flight
// bursts with a credit counter and pulses ctrl_done when all have returned.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for ctrl_start
// ST_ISSUE | issuing AR bursts while beats remain and credit allows
// ST_DRAIN | all ARs issued; waiting for outstanding bursts to complete
// ST_DONE  | one-cycle completion, ctrl_done high
module xtime_rd_ar_issuer
  import xtime_axi_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_WIDTH      = 32,
  parameter int C_BYTES_PER_BEAT  = 64,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [C_XFER_WIDTH-1:0] ctrl_xfer_beats,
  output logic                    ctrl_done,
  output logic                    ctrl_busy,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  input  logic                    burst_done,
  output logic                    err_underflow
);

  localparam int LP_BURST_BYTES = calc_burst_bytes(C_BURST_LEN, C_BYTES_PER_BEAT);
  localparam int LP_CNT_W       = calc_cnt_width(C_MAX_OUTSTANDING);

  xtime_ar_state_e         state_q, state_d;
  logic [C_XFER_WIDTH-1:0] remaining_q, remaining_d, rem_after_hs;
  logic [C_ADDR_WIDTH-1:0] araddr_d;
  logic [7:0]              arlen_d;
  logic                    arvalid_d, done_d, busy_d;
  logic [LP_CNT_W-1:0]     out_cnt;
  logic                    cnt_zero, ar_hs, cnt_decr, credit_ok, credit_after_hs;

  assign ar_hs        = m_axi_arvalid & m_axi_arready;
  assign cnt_decr     = burst_done & ~cnt_zero;
  assign rem_after_hs = remaining_q - (C_XFER_WIDTH'(m_axi_arlen) + C_XFER_WIDTH'(1));
  // Credit looks only at the registered count plus this cycle's issue, so a
  // burst_done frees a slot two cycles later.
  assign credit_ok       = 32'(out_cnt) < 32'(C_MAX_OUTSTANDING);
  assign credit_after_hs = (32'(out_cnt) + 32'd1) < 32'(C_MAX_OUTSTANDING);

  function automatic logic [7:0] burst_arlen(input logic [C_XFER_WIDTH-1:0] rem);
    if (rem == '0) return 8'd0;
    if (64'(rem) >= 64'(C_BURST_LEN)) return 8'(C_BURST_LEN - 1);
    return 8'(rem - C_XFER_WIDTH'(1));
  endfunction

  alt_counter #(
    .C_WIDTH (LP_CNT_W),
    .C_INIT  ('0)
  ) u_out_cnt (
    .clk        (aclk),
    .rst        (areset),
    .load       (1'b0),
    .load_value ('0),
    .incr       (ar_hs),
    .decr       (cnt_decr),
    .count      (out_cnt),
    .is_zero    (cnt_zero)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A zero-length transfer passes through DRAIN (count is
  // already zero) so ctrl_done lands two cycles after the start pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ctrl_start) state_d = (ctrl_xfer_beats == '0) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (ar_hs && rem_after_hs == '0) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_zero) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; an asserted AR is held until accepted.
  always_comb begin
    araddr_d    = m_axi_araddr;
    arlen_d     = m_axi_arlen;
    remaining_d = remaining_q;
    arvalid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          araddr_d    = ctrl_addr;
          remaining_d = ctrl_xfer_beats;
          arlen_d     = burst_arlen(ctrl_xfer_beats);
          arvalid_d   = (ctrl_xfer_beats != '0) && credit_ok;
        end
      end
      ST_ISSUE: begin
        if (ar_hs) begin
          araddr_d    = m_axi_araddr + C_ADDR_WIDTH'(LP_BURST_BYTES);
          remaining_d = rem_after_hs;
          arlen_d     = burst_arlen(rem_after_hs);
          arvalid_d   = (rem_after_hs != '0) && credit_after_hs;
        end else begin
          arvalid_d   = m_axi_arvalid | ((remaining_q != '0) && credit_ok);
        end
      end
      default: ;
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // Output and datapath registers; underflow error is sticky until reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      remaining_q   <= '0;
      ctrl_done     <= 1'b0;
      ctrl_busy     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      m_axi_arvalid <= arvalid_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arlen   <= arlen_d;
      remaining_q   <= remaining_d;
      ctrl_done     <= done_d;
      ctrl_busy     <= busy_d;
      err_underflow <= err_underflow | (burst_done & cnt_zero);
    end
  end

endmodule
